md_scheduler: RTL and testbench

//  Sequences the HI/LO multiply-divide unit for the pipelined MIPS core. Sits between the
//  E stage and the MD unit. Issues one MD op per request and tracks its latency with its
//  own counter. Raises stall_d to hold the D stage while HI/LO is in use.

---
 rtl/md_scheduler_pkg.sv | 48 ++++
 rtl/md_scheduler_lat_counter.sv | 25 ++
 rtl/md_scheduler.sv | 94 +++++++++
 tb/tb_md_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the HI/LO multiply-divide scheduler: opcodes, op classes,
// default latencies and the class-decode helper.
package md_defs;

  localparam logic [3:0] MD_MULT  = 4'b0000;
  localparam logic [3:0] MD_MULTU = 4'b0001;
  localparam logic [3:0] MD_DIV   = 4'b0010;
  localparam logic [3:0] MD_DIVU  = 4'b0011;
  localparam logic [3:0] MD_MTHI  = 4'b0100;
  localparam logic [3:0] MD_MTLO  = 4'b0101;
  localparam logic [3:0] MD_MFHI  = 4'b0110;
  localparam logic [3:0] MD_MFLO  = 4'b0111;
  localparam logic [3:0] MD_NOP   = 4'b1000;
  localparam logic [3:0] MD_MADD  = 4'b1001;
  localparam logic [3:0] MD_MADDU = 4'b1010;
  localparam logic [3:0] MD_MSUB  = 4'b1011;
  localparam logic [3:0] MD_MSUBU = 4'b1100;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    MD_CLS_NONE,
    MD_CLS_LONG,
    MD_CLS_SHORT,
    MD_CLS_READ
  } md_cls_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  function automatic md_cls_e md_class(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return MD_CLS_LONG;
      MD_MTHI, MD_MTLO:                     return MD_CLS_SHORT;
      MD_MFHI, MD_MFLO:                     return MD_CLS_READ;
      default:                              return MD_CLS_NONE;
    endcase
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_lat_counter.sv
// Load/decrement latency counter; holds at zero and flags it.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply-divide scheduler: issues one MD op per accepted request, tracks its
// latency and stalls D while a HI/LO result is still pending.
//
// state | meaning
// IDLE  | no result pending; E may issue long/short ops or read HI/LO
// RUN   | long op in flight; count holds cycles left until HI/LO is valid
module md_scheduler
  import md_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             e_valid,
  input  logic [3:0]       e_op,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             e_flush,
  input  logic             d_md_use,
  output logic [3:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  output logic             md_issue,
  output logic             busy,
  output logic             stall_d,
  output logic [CNT_W-1:0] rem_cnt
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

  md_state_e        state, state_nxt;
  md_cls_e          cls;
  logic             acc;
  logic             start_long;
  logic [CNT_W-1:0] count;
  logic             cnt_zero;
  logic [31:0]      a_q, b_q;

  assign cls = md_class(e_op);
  // reset_n gates accept so nothing issues combinationally while reset is held
  assign acc        = reset_n & e_valid & ~e_flush & (state == ST_IDLE);
  assign start_long = acc & (cls == MD_CLS_LONG);

  md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start_long),
    .load_val (md_is_div(e_op) ? DIV_LD : MULT_LD),
    .dec      (state == ST_RUN),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      if (md_issue) begin
        a_q <= e_rs;
        b_q <= e_rt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_long) state_nxt = ST_RUN;
      ST_RUN:  if (cnt_zero || (count == CNT_W'(1))) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    md_issue = acc & ((cls == MD_CLS_LONG) | (cls == MD_CLS_SHORT));
    md_op    = md_issue ? e_op : MD_NOP;
    md_a     = md_issue ? e_rs : a_q;
    md_b     = md_issue ? e_rt : b_q;
    busy     = (state == ST_RUN);
    stall_d  = d_md_use & (busy | start_long);
    rem_cnt  = count;
  end

  // stall_d must keep every MD op out of E while a long op is in flight
  ap_no_req_in_run: assert property (@(posedge clk) disable iff (!reset_n)
    !(e_valid && (state == ST_RUN)));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-count model.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rs = '0, e_rt = '0;
  logic        e_flush = 1'b0;
  logic        d_md_use = 1'b0;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_issue, busy, stall_d;
  logic [3:0]  rem_cnt;

  int checks = 0;
  int errors = 0;

  // model: cycles of busy remaining, and operands of the last issued op
  int          m_rem = 0;
  logic [31:0] m_a = '0, m_b = '0;

  md_scheduler dut (
    .clk(clk), .reset_n(reset_n), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .e_flush(e_flush), .d_md_use(d_md_use), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_issue(md_issue), .busy(busy), .stall_d(stall_d), .rem_cnt(rem_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int op_lat(input logic [3:0] op);
    if (op inside {4'd2, 4'd3}) return 10;
    if (op inside {4'd0, 4'd1, 4'd9, 4'd10, 4'd11, 4'd12}) return 5;
    return 0;
  endfunction

  function automatic bit op_short(input logic [3:0] op);
    return op inside {4'd4, 4'd5};
  endfunction

  function automatic bit m_acc();
    return reset_n && e_valid && !e_flush && (m_rem == 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem = 0; m_a = '0; m_b = '0;
    end else begin
      if (m_acc() && (op_lat(e_op) > 0 || op_short(e_op))) begin
        m_a = e_rs; m_b = e_rt;
      end
      if (m_acc() && op_lat(e_op) > 0) m_rem = op_lat(e_op) - 1;
      else if (m_rem > 0) m_rem = m_rem - 1;
    end
  end

  always @(negedge clk) begin
    bit iss;
    iss = m_acc() && (op_lat(e_op) > 0 || op_short(e_op));
    chk("issue", md_issue, iss);
    chk("op", md_op, iss ? e_op : 4'b1000);
    chk("a", md_a, iss ? e_rs : m_a);
    chk("b", md_b, iss ? e_rt : m_b);
    chk("busy", busy, m_rem > 0);
    chk("rem", rem_cnt, m_rem);
    chk("stall", stall_d, d_md_use && (m_rem > 0 || (m_acc() && op_lat(e_op) > 0)));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl, input logic d);
    e_valid = v; e_op = op; e_rs = rs; e_rt = rt; e_flush = fl; d_md_use = d;
    #1;
  endtask

  task automatic idle(input logic d);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, d);
  endtask

  logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};

  initial begin
    #2;
    chk("rst_op", md_op, 4'b1000);
    chk("rst_busy", busy, 1'b0);
    tick(); tick();
    reset_n = 1'b1;

    // 1: mult 7 * -3, mflo waiting in D
    tick(); drive(1'b1, 4'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1);
    chk("t1_issue", md_issue, 1'b1);
    chk("t1_a", md_a, 32'd7);
    chk("t1_stall0", stall_d, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle(1'b1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_stall", stall_d, 1'b1);
    end
    tick(); drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_busy5", busy, 1'b0);
    chk("t1_mflo_noissue", md_issue, 1'b0);

    // 2: div 100/7, rem_cnt 9..1
    tick(); drive(1'b1, 4'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick(); idle(1'b0);
      chk("t2_rem", rem_cnt, 10 - k);
    end
    tick(); idle(1'b0);
    chk("t2_busy10", busy, 1'b0);

    // 3: flushed request, then flush during a div
    tick(); drive(1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 1'b1);
    chk("t3_noissue", md_issue, 1'b0);
    chk("t3_nostall", stall_d, 1'b0);
    tick(); idle(1'b0);
    chk("t3_notbusy", busy, 1'b0);
    tick(); drive(1'b1, 4'd3, 32'd9, 32'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick(); drive(1'b0, 4'd0, 32'd0, 32'd0, k == 3, 1'b0);
      chk("t3_busy", busy, 1'b1);
    end
    tick(); idle(1'b0);
    chk("t3_done", busy, 1'b0);

    // 4: mthi alone, then mthi held behind a mult
    tick(); drive(1'b1, 4'd4, 32'h1234, 32'd0, 1'b0, 1'b1);
    chk("t4_issue", md_issue, 1'b1);
    chk("t4_op", md_op, 4'd4);
    chk("t4_nostall", stall_d, 1'b0);
    tick(); drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0, 1'b1);
    chk("t4_stall", stall_d, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle(1'b1);
      chk("t4_hold", stall_d, 1'b1);
    end
    tick(); drive(1'b1, 4'd4, 32'h55, 32'd0, 1'b0, 1'b0);
    chk("t4_mthi_go", md_issue, 1'b1);

    // 5: asynchronous reset mid-div
    tick(); drive(1'b1, 4'd2, 32'd50, 32'd5, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin tick(); idle(1'b1); end
    tick(); idle(1'b1);
    chk("t5_busy_pre", busy, 1'b1);
    reset_n = 1'b0; #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_stall", stall_d, 1'b0);
    chk("t5_rem", rem_cnt, 4'd0);
    chk("t5_a", md_a, 32'd0);
    tick(); reset_n = 1'b1; idle(1'b0);
    tick(); drive(1'b1, 4'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("t5_reissue", md_issue, 1'b1);
    tick(); idle(1'b0);
    chk("t5_rem4", rem_cnt, 4'd4);
    for (int k = 0; k < 4; k++) begin tick(); idle(1'b0); end

    // 6: back-to-back madd
    tick(); drive(1'b1, 4'd9, 32'd2, 32'd3, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle(1'b1);
      chk("t6_noissue", md_issue, 1'b0);
    end
    tick(); drive(1'b1, 4'd9, 32'd4, 32'd5, 1'b0, 1'b0);
    chk("t6_issue5", md_issue, 1'b1);
    chk("t6_busy5", busy, 1'b0);
    tick(); idle(1'b0);
    chk("t6_rem", rem_cnt, 4'd4);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
      drive((m_rem == 0) && ($urandom_range(0, 2) == 0), ops[$urandom_range(0, 11)],
            $urandom, $urandom, $urandom_range(0, 4) == 0, 1'(($urandom_range(0, 1))));
    end
    tick(); idle(1'b0);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
